// File: rtl/cy_motion_ctrl_pkg.sv
// Shared types and helpers for the CY sprite motion controller and its pixel selector:
// facing enum, sprite frame-index constants, frame lookup and clamped step arithmetic.
package cy_motion_ctrl_pkg;

   typedef enum logic [1:0] {
      FACE_DOWN  = 2'd0,
      FACE_UP    = 2'd1,
      FACE_LEFT  = 2'd2,
      FACE_RIGHT = 2'd3
   } facing_e;

   localparam logic [3:0] FRAME_FRONT_STAND  = 4'd0;
   localparam logic [3:0] FRAME_FRONT_WALK_L = 4'd1;
   localparam logic [3:0] FRAME_FRONT_WALK_R = 4'd2;
   localparam logic [3:0] FRAME_BACK_STAND   = 4'd3;
   localparam logic [3:0] FRAME_BACK_WALK_L  = 4'd4;
   localparam logic [3:0] FRAME_BACK_WALK_R  = 4'd5;
   localparam logic [3:0] FRAME_LEFT_STAND   = 4'd6;
   localparam logic [3:0] FRAME_LEFT_WALK    = 4'd7;
   localparam logic [3:0] FRAME_RIGHT_STAND  = 4'd8;
   localparam logic [3:0] FRAME_RIGHT_WALK   = 4'd9;

   localparam int POS_W = 11;

   // Even phases show the standing pose; odd phases alternate the walking poses.
   function automatic logic [3:0] frame_index(input facing_e facing, input logic [1:0] phase);
      logic [3:0] idx;
      idx = FRAME_FRONT_STAND;
      case (facing)
         FACE_DOWN: begin
            case (phase)
               2'd1:    idx = FRAME_FRONT_WALK_L;
               2'd3:    idx = FRAME_FRONT_WALK_R;
               default: idx = FRAME_FRONT_STAND;
            endcase
         end
         FACE_UP: begin
            case (phase)
               2'd1:    idx = FRAME_BACK_WALK_L;
               2'd3:    idx = FRAME_BACK_WALK_R;
               default: idx = FRAME_BACK_STAND;
            endcase
         end
         FACE_LEFT:  idx = phase[0] ? FRAME_LEFT_WALK  : FRAME_LEFT_STAND;
         FACE_RIGHT: idx = phase[0] ? FRAME_RIGHT_WALK : FRAME_RIGHT_STAND;
         default:    idx = FRAME_FRONT_STAND;
      endcase
      return idx;
   endfunction

   function automatic logic [POS_W-1:0] step_toward_min(input logic [POS_W-1:0] pos,
                                                         input logic [POS_W-1:0] min_pos,
                                                         input logic [POS_W-1:0] step);
      return (pos < min_pos + step) ? min_pos : pos - step;
   endfunction

   function automatic logic [POS_W-1:0] step_toward_max(input logic [POS_W-1:0] pos,
                                                         input logic [POS_W-1:0] max_pos,
                                                         input logic [POS_W-1:0] step);
      return (pos + step > max_pos) ? max_pos : pos + step;
   endfunction

endpackage

// File: rtl/cy_motion_ctrl_anim_phase_counter.sv
// Walk-animation timebase: divider counting 0..ANIM_DIV-1 and a 2-bit phase that advances
// at terminal count. Exposes the next phase so the owner can register a frame in step with it.
module anim_phase_counter #(
   parameter int ANIM_DIV = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       clear,
   output logic [1:0] phase_next
);

   localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_next;
   logic [1:0]       phase;

   always_comb begin
      // NOTE: every variable gets a default up front so no branch can infer a latch.
      div_next   = div_cnt;
      phase_next = phase;
      if (clear) begin
         div_next   = '0;
         phase_next = 2'd0;
      end else if (en) begin
         if (div_cnt == DIV_LAST) begin
            div_next   = '0;
            phase_next = phase + 2'd1;
         end else begin
            div_next = div_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         div_cnt <= '0;
         phase   <= 2'd0;
      end else begin
         div_cnt <= div_next;
         phase   <= phase_next;
      end
   end

endmodule

// File: rtl/cy_motion_ctrl.sv
// CY sprite motion controller: WASD keys -> clamped sprite position, facing and animation frame.
// Define CY_DIAGONAL_EN to let both axes move in one cycle; otherwise one axis per cycle (W > S > A > D).
module cy_motion_ctrl
   import cy_motion_ctrl_pkg::*;
#(
   parameter int STEP     = 2,
   parameter int H_MIN    = 0,
   parameter int H_MAX    = 620,
   parameter int V_MIN    = 0,
   parameter int V_MAX    = 460,
   parameter int H_INIT   = 310,
   parameter int V_INIT   = 230,
   parameter int ANIM_DIV = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       W_signal,
   input  logic       S_signal,
   input  logic       A_signal,
   input  logic       D_signal,
   output logic [9:0] pos_h,
   output logic [9:0] pos_v,
   output logic [3:0] pixel_idx_CY,
   output logic       moving
);

   localparam logic [POS_W-1:0] STEP_P  = POS_W'(STEP);
   localparam logic [POS_W-1:0] H_MIN_P = POS_W'(H_MIN);
   localparam logic [POS_W-1:0] H_MAX_P = POS_W'(H_MAX);
   localparam logic [POS_W-1:0] V_MIN_P = POS_W'(V_MIN);
   localparam logic [POS_W-1:0] V_MAX_P = POS_W'(V_MAX);

   facing_e          facing;
   facing_e          facing_next;
   logic             go_up, go_down, go_left, go_right;
   logic             v_active, h_active, move_h;
   logic             moving_next;
   logic [POS_W-1:0] pos_h_next, pos_v_next;
   logic [1:0]       phase_next;

   // Opposing keys on one axis cancel.
   assign go_up    = W_signal & ~S_signal;
   assign go_down  = S_signal & ~W_signal;
   assign go_left  = A_signal & ~D_signal;
   assign go_right = D_signal & ~A_signal;
   assign v_active = go_up | go_down;
   assign h_active = go_left | go_right;
   assign moving_next = v_active | h_active;

`ifdef CY_DIAGONAL_EN
   assign move_h = h_active;
`else
   assign move_h = h_active & ~v_active;
`endif

   always_comb begin
      pos_h_next  = {1'b0, pos_h};
      pos_v_next  = {1'b0, pos_v};
      facing_next = facing;

      if (go_up) begin
         pos_v_next  = step_toward_min({1'b0, pos_v}, V_MIN_P, STEP_P);
         facing_next = FACE_UP;
      end else if (go_down) begin
         pos_v_next  = step_toward_max({1'b0, pos_v}, V_MAX_P, STEP_P);
         facing_next = FACE_DOWN;
      end

      if (move_h) begin
         if (go_left) begin
            pos_h_next = step_toward_min({1'b0, pos_h}, H_MIN_P, STEP_P);
         end else begin
            pos_h_next = step_toward_max({1'b0, pos_h}, H_MAX_P, STEP_P);
         end
         // Vertical motion owns the facing when both axes move.
         if (!v_active) begin
            facing_next = go_left ? FACE_LEFT : FACE_RIGHT;
         end
      end
   end

   // Divider and phase keep running across facing changes; only standing still clears them.
   anim_phase_counter #(
      .ANIM_DIV (ANIM_DIV)
   ) u_anim_phase_counter (
      .clk        (clk),
      .rst        (rst),
      .en         (moving_next),
      .clear      (~moving_next),
      .phase_next (phase_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_h        <= 10'(H_INIT);
         pos_v        <= 10'(V_INIT);
         facing       <= FACE_DOWN;
         moving       <= 1'b0;
         pixel_idx_CY <= FRAME_FRONT_STAND;
      end else begin
         pos_h        <= pos_h_next[9:0];
         pos_v        <= pos_v_next[9:0];
         facing       <= facing_next;
         moving       <= moving_next;
         pixel_idx_CY <= frame_index(facing_next, phase_next);
      end
   end

endmodule

// File: tb/tb_cy_motion_ctrl.sv
// Self-checking bench for cy_motion_ctrl: directed boundary scenarios plus randomized key
// streams, compared each cycle against an arithmetic reference model.
module tb_cy_motion_ctrl;

   localparam int STEP     = 2;
   localparam int H_MIN    = 0;
   localparam int H_MAX    = 620;
   localparam int V_MIN    = 0;
   localparam int V_MAX    = 460;
   localparam int H_INIT   = 310;
   localparam int V_INIT   = 230;
   localparam int ANIM_DIV = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       W_signal, S_signal, A_signal, D_signal;
   logic [9:0] pos_h, pos_v;
   logic [3:0] pixel_idx_CY;
   logic       moving;

   int total = 0;
   int bad   = 0;
   string scene = "init";

   // Reference state: facing 0=down 1=up 2=left 3=right; run = consecutive moving cycles.
   int m_h, m_v, m_face, m_run;
   int m_mov;
   int frame_tab [4][4] = '{'{0, 1, 0, 2}, '{3, 4, 3, 5}, '{6, 7, 6, 7}, '{8, 9, 8, 9}};

   always #5 clk = ~clk;

   cy_motion_ctrl #(
      .STEP (STEP), .H_MIN (H_MIN), .H_MAX (H_MAX), .V_MIN (V_MIN), .V_MAX (V_MAX),
      .H_INIT (H_INIT), .V_INIT (V_INIT), .ANIM_DIV (ANIM_DIV)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .W_signal     (W_signal),
      .S_signal     (S_signal),
      .A_signal     (A_signal),
      .D_signal     (D_signal),
      .pos_h        (pos_h),
      .pos_v        (pos_v),
      .pixel_idx_CY (pixel_idx_CY),
      .moving       (moving)
   );

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s/%s: got %0d expected %0d", scene, tag, got, exp);
      end
   endtask

   function automatic int clampi(input int x, input int lo, input int hi);
      if (x < lo) return lo;
      if (x > hi) return hi;
      return x;
   endfunction

   task automatic model_update(input bit r, input bit kw, input bit ks, input bit ka, input bit kd);
      int dv, dh;
      bit diag;
`ifdef CY_DIAGONAL_EN
      diag = 1'b1;
`else
      diag = 1'b0;
`endif
      if (r) begin
         m_h = H_INIT; m_v = V_INIT; m_face = 0; m_run = 0; m_mov = 0;
         return;
      end
      dv = int'(ks) - int'(kw);
      dh = int'(kd) - int'(ka);
      m_mov = (dv != 0 || dh != 0) ? 1 : 0;
      m_run = m_mov ? m_run + 1 : 0;
      if (dv != 0) m_v = clampi(m_v + dv * STEP, V_MIN, V_MAX);
      if (dh != 0 && (diag || dv == 0)) m_h = clampi(m_h + dh * STEP, H_MIN, H_MAX);
      if (dv < 0)      m_face = 1;
      else if (dv > 0) m_face = 0;
      else if (dh < 0) m_face = 2;
      else if (dh > 0) m_face = 3;
   endtask

   // Drive keys, clock once, advance the model, then compare all outputs 1 ns after the edge.
   task automatic step(input bit r, input bit kw, input bit ks, input bit ka, input bit kd);
      rst = r; W_signal = kw; S_signal = ks; A_signal = ka; D_signal = kd;
      @(posedge clk);
      model_update(r, kw, ks, ka, kd);
      #1;
      check("pos_h",  int'(pos_h), m_h);
      check("pos_v",  int'(pos_v), m_v);
      check("moving", int'(moving), m_mov);
      check("pixel",  int'(pixel_idx_CY), frame_tab[m_face][(m_run / ANIM_DIV) % 4]);
   endtask

   initial begin
      int k;
      int guard;
      bit [3:0] keys;
      m_h = 0; m_v = 0; m_face = 0; m_run = 0; m_mov = 0;
      rst = 1'b1; W_signal = 1'b0; S_signal = 1'b0; A_signal = 1'b0; D_signal = 1'b0;

      scene = "reset";
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 1, 0);
      check("reset_h_abs", int'(pos_h), 310);
      check("reset_v_abs", int'(pos_v), 230);
      check("reset_px_abs", int'(pixel_idx_CY), 0);

      scene = "idle";
      for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);

      scene = "right";
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0, 1);
         check("right_abs", int'(pos_h), 312 + 2 * i);
      end
      for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 1);

      scene = "left_bound";
      guard = 0;
      while (m_h > 0 && guard < 400) begin
         step(0, 0, 0, 1, 0);
         guard++;
      end
      check("left_reached", m_h, 0);
      for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0);
      check("left_hold_abs", int'(pos_h), 0);

      scene = "cancel_v";
      step(0, 1, 1, 0, 0);
      check("cancel_stand_abs", int'(pixel_idx_CY), 6);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);

      scene = "up_right";
      for (int i = 0; i < 40; i++) step(0, 1, 0, 0, 1);

      scene = "down_bound";
      for (int i = 0; i < 260; i++) step(0, 0, 1, 0, 0);
      check("down_hold_abs", int'(pos_v), V_MAX);

      scene = "mid_rst";
      for (int i = 0; i < 11; i++) step(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      check("mid_rst_px_abs", int'(pixel_idx_CY), 0);
      step(0, 0, 0, 0, 1);

      scene = "random";
      keys = 4'b0000;
      for (int i = 0; i < 4000; i++) begin
         k = int'($urandom_range(0, 15));
         if (k == 0) keys = 4'($urandom_range(0, 15));
         step(($urandom_range(0, 199) == 0), keys[3], keys[2], keys[1], keys[0]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cy_motion_ctrl.md
CY_MOTION_CTRL -- requirements
Module: cy_motion_ctrl

Interface
REQ-001 Parameter STEP, 2, pixels moved per clk cycle per axis.
REQ-002 Parameter H_MIN, 0, leftmost legal pos_h.
REQ-003 Parameter H_MAX, 620, rightmost legal pos_h (640 minus 20-px sprite).
REQ-004 Parameter V_MIN, 0, topmost legal pos_v.
REQ-005 Parameter V_MAX, 460, bottommost legal pos_v (480 minus 20-px sprite).
REQ-006 Parameter H_INIT / V_INIT, 310 / 230, position after reset.
REQ-007 Parameter ANIM_DIV, 8, clk cycles per animation phase, >=1.
REQ-008 clk  in  1  state-control clock (divided clock, one step per cycle); single clock domain.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 W_signal / S_signal / A_signal / D_signal  in  1 each  level key-held: up / down / left / right.
REQ-011 pos_h  out  10  sprite top-left column, registered.
REQ-012 pos_v  out  10  sprite top-left row, registered.
REQ-013 pixel_idx_CY  out  4  sprite frame index for the pixel selector, registered.
REQ-014 moving  out  1  high while a net movement direction is active, registered.

Function
REQ-015 Net axis direction: W xor S gives vertical (W=up, S=down); A xor D gives horizontal (A=left, D=right); both keys of an axis held = no motion on that axis.
REQ-016 All outputs update on the clk edge after keys are sampled; latency exactly 1 cycle, no combinational key-to-output path.
REQ-017 Position arithmetic in 11 bits; up/left: new = (pos < MIN+STEP) ? MIN : pos-STEP; down/right: new = (pos+STEP > MAX) ? MAX : pos+STEP; never wraps.
REQ-018 Facing FSM states FACE_DOWN, FACE_UP, FACE_LEFT, FACE_RIGHT; facing becomes the direction actually moved (vertical takes precedence when both axes move); no net direction keeps facing unchanged.
REQ-019 Animation: divider counts 0..ANIM_DIV-1 while moving; at terminal count the 2-bit phase advances 0->1->2->3->0; when not moving, divider and phase clear to 0 in the same cycle.
REQ-020 Frame indices: 0 front_stand, 1 front_walk_L, 2 front_walk_R, 3 back_stand, 4 back_walk_L, 5 back_walk_R, 6 left_stand, 7 left_walk, 8 right_stand, 9 right_walk; 10-15 never emitted.
REQ-021 Down/up facing: phase 0,2 -> stand, 1 -> walk_L, 3 -> walk_R; left/right facing: phase 0,2 -> stand, 1,3 -> walk.
REQ-022 moving asserts on net direction even when clamped at a bound (walking in place); position holds at bound.
REQ-023 Facing change mid-walk keeps phase/divider running; only frame base changes.

Reset
REQ-024 rst high at a clk edge: pos_h=H_INIT, pos_v=V_INIT, facing=FACE_DOWN, phase=0, divider=0, moving=0, pixel_idx_CY=0; keys ignored that cycle.
REQ-025 Reset mid-walk takes priority over any move in the same cycle; first move occurs the cycle after rst deasserts.

Configuration
REQ-026 Macro CY_DIAGONAL_EN defined: both axes move in the same cycle per REQ-017.
REQ-027 CY_DIAGONAL_EN undefined: single axis per cycle, priority W > S > A > D after REQ-015 cancellation; facing follows the chosen key.

Structure
REQ-028 Shared package holds the facing enum and the ten frame-index constants, also used by the pixel selector.
REQ-029 One sub-module, anim_phase_counter (divider + 2-bit phase, inputs en/clear), is instantiated once.

Verification
REQ-030 Reset, no keys, 20 cycles -> pos (310,230), pixel_idx_CY=0, moving=0 throughout.
REQ-031 D held 5 cycles -> pos_h 312,314,316,318,320 one cycle late; facing right; frames 8 for phases 0/2, 9 for 1/3, phase change every 8 cycles.
REQ-032 A held from pos_h=1 -> pos_h=0 next cycle, stays 0, moving=1, frames 6/7 alternate.
REQ-033 W and S held together, no A/D -> pos unchanged, moving=0, pixel_idx_CY = stand of prior facing.
REQ-034 W+D held: with CY_DIAGONAL_EN pos (+2,-2)/cycle, frames 3/4/5; without, pos_v -2/cycle only, pos_h fixed.
REQ-035 rst pulsed mid-walk at (400,100) -> next cycle (310,230), frame 0, moving=0.
